// File: rtl/uart_dbg_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_dbg_pkg
//  Description : Shared types and constants for the serial debug unit.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_dbg_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } tx_sched_state_t;

    // One bit time at 9600 baud from a 50 MHz clock.
    localparam int BIT_TICKS = 5208;

    // Width of a counter that must hold 0..max_val, never narrower than 1 bit.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ============================================================================
//  Module      : rr_pick
//  Description : Rotating priority encoder; first set request after ptr.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_pick #(
    parameter int NREQ = 4,
    parameter int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [IW-1:0]   idx,
    output logic            any
);

    // Scan from the farthest position down so the nearest one after ptr wins.
    always_comb begin
        idx = '0;
        any = 1'b0;
        for (int k = NREQ; k >= 1; k--) begin
            if (req[(int'(ptr) + k) % NREQ]) begin
                idx = IW'((int'(ptr) + k) % NREQ);
                any = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_tx_sched.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_sched
//  Description : Message-level round-robin scheduler in front of the UART TX.
//                Optional stall abort built when TX_TIMEOUT_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_sched
    import uart_dbg_pkg::*;
#(
    parameter int NREQ      = 4,
    parameter int GAP_TICKS = BIT_TICKS,
    parameter int TIMEOUT   = 65535
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req,
    input  logic [8*NREQ-1:0]       data,
    input  logic [NREQ-1:0]         last,
    output logic [NREQ-1:0]         ack,
    output logic [7:0]              tx_data,
    output logic                    tx_vld,
    input  logic                    tx_rdy,
    output logic                    busy,
    output logic [$clog2(NREQ)-1:0] grant_id,
    output logic                    err_timeout
);

    localparam int IW         = $clog2(NREQ);
    localparam int GW         = cnt_width(GAP_TICKS);
    localparam int c_gap_last = (GAP_TICKS > 0) ? GAP_TICKS - 1 : 0;

    tx_sched_state_t r_state, w_state_nxt;

    logic [IW-1:0]   r_ptr;
    logic [IW-1:0]   r_grant_id;
    logic [NREQ-1:0] r_ack;
    logic [7:0]      r_tx_data;
    logic            r_tx_vld;
    logic            r_last;
    logic            r_busy;
    logic [GW-1:0]   r_gap_cnt;

    logic [IW-1:0]   w_pick;
    logic            w_any;
    logic            w_sel_req;
    logic            w_sel_last;
    logic [7:0]      w_sel_data;
    logic            w_capture;
    logic            w_xfer;
    logic            w_gap_done;
    logic            w_tmo_hit;

    rr_pick #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_rr_pick (
        .req  (req),
        .ptr  (r_ptr),
        .idx  (w_pick),
        .any  (w_any)
    );

    always_comb begin
        w_sel_req  = 1'b0;
        w_sel_last = 1'b0;
        w_sel_data = 8'h00;
        for (int i = 0; i < NREQ; i++) begin
            if (IW'(i) == r_grant_id) begin
                w_sel_req  = req[i];
                w_sel_last = last[i];
                w_sel_data = data[8*i +: 8];
            end
        end
    end

    assign w_capture  = (r_state == SEND) && !r_tx_vld && w_sel_req;
    assign w_xfer     = (r_state == SEND) && r_tx_vld && tx_rdy;
    assign w_gap_done = (r_state == GAP) && (r_gap_cnt == GW'(c_gap_last));

`ifdef TX_TIMEOUT_EN
    localparam int TW         = cnt_width(TIMEOUT);
    localparam int c_tmo_last = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

    logic [TW-1:0] r_tmo_cnt;
    logic          r_err_timeout;
    logic          w_starved;

    // Starved: nothing in flight and the grantee has nothing to offer.
    assign w_starved = (r_state == SEND) && !r_tx_vld && !w_sel_req;
    assign w_tmo_hit = w_starved && (r_tmo_cnt == TW'(c_tmo_last));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tmo_cnt     <= '0;
            r_err_timeout <= 1'b0;
        end else begin
            r_err_timeout <= w_tmo_hit;
            if ((r_state != SEND) || w_capture || w_tmo_hit) begin
                r_tmo_cnt <= '0;
            end else if (w_starved && (r_tmo_cnt != TW'(TIMEOUT))) begin
                r_tmo_cnt <= r_tmo_cnt + 1'b1;
            end
        end
    end

    assign err_timeout = r_err_timeout;
`else
    assign w_tmo_hit   = 1'b0;
    assign err_timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_state_nxt = SEND;
                end
            end
            SEND: begin
                if ((w_xfer && r_last) || w_tmo_hit) begin
                    w_state_nxt = (GAP_TICKS == 0) ? IDLE : GAP;
                end
            end
            GAP: begin
                if (w_gap_done) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr      <= IW'(NREQ - 1);
            r_grant_id <= '0;
            r_ack      <= '0;
            r_tx_data  <= 8'h00;
            r_tx_vld   <= 1'b0;
            r_last     <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_ack  <= '0;
            r_busy <= (w_state_nxt != IDLE);
            if ((r_state == IDLE) && w_any) begin
                r_grant_id <= w_pick;
                r_ptr      <= w_pick;
            end
            if (w_capture) begin
                r_tx_data <= w_sel_data;
                r_tx_vld  <= 1'b1;
                r_last    <= w_sel_last;
                r_ack     <= NREQ'(1) << r_grant_id;
            end
            if (w_xfer) begin
                r_tx_vld <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || (r_state != GAP) || w_gap_done) begin
            r_gap_cnt <= '0;
        end else begin
            r_gap_cnt <= r_gap_cnt + 1'b1;
        end
    end

    assign ack      = r_ack;
    assign tx_data  = r_tx_data;
    assign tx_vld   = r_tx_vld;
    assign busy     = r_busy;
    assign grant_id = r_grant_id;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_tx_sched
//  Description : Directed self-checking bench for uart_tx_sched.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_sched;

    localparam int NREQ    = 4;
    localparam int GAP     = 4;
    localparam int TMO     = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req;
    logic [8*NREQ-1:0] data;
    logic [NREQ-1:0]   last;
    logic [NREQ-1:0]   ack;
    logic [7:0]        tx_data;
    logic              tx_vld;
    logic              tx_rdy;
    logic              busy;
    logic [1:0]        grant_id;
    logic              err_timeout;

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;

    logic [8:0] rq [NREQ][$];
    logic [7:0] log_byte[$];
    int         log_cyc[$];
    int         ack_cnt[NREQ];

    uart_tx_sched #(
        .NREQ      (NREQ),
        .GAP_TICKS (GAP),
        .TIMEOUT   (TMO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .data        (data),
        .last        (last),
        .ack         (ack),
        .tx_data     (tx_data),
        .tx_vld      (tx_vld),
        .tx_rdy      (tx_rdy),
        .busy        (busy),
        .grant_id    (grant_id),
        .err_timeout (err_timeout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Requester model: pop on ack, then present the head of each queue.
    always @(posedge clk) begin
        #2;
        for (int i = 0; i < NREQ; i++) begin
            if (ack[i] && rq[i].size() > 0) void'(rq[i].pop_front());
            if (rq[i].size() > 0) begin
                req[i]          = 1'b1;
                data[8*i +: 8]  = rq[i][0][7:0];
                last[i]         = rq[i][0][8];
            end else begin
                req[i]          = 1'b0;
                data[8*i +: 8]  = 8'h00;
                last[i]         = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (tx_vld && tx_rdy) begin
                log_byte.push_back(tx_data);
                log_cyc.push_back(cyc);
            end
            for (int i = 0; i < NREQ; i++) ack_cnt[i] += int'(ack[i]);
        end
    end

    task automatic push(input int i, input logic [7:0] d, input logic l);
        rq[i].push_back({l, d});
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        for (int i = 0; i < NREQ; i++) begin
            rq[i].delete();
            ack_cnt[i] = 0;
        end
        log_byte.delete();
        log_cyc.delete();
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_ack"},  32'(ack), 32'h0);
        chk({tag, "_vld"},  32'(tx_vld), 32'h0);
        chk({tag, "_data"}, 32'(tx_data), 32'h0);
        chk({tag, "_busy"}, 32'(busy), 32'h0);
        chk({tag, "_gid"},  32'(grant_id), 32'h0);
        chk({tag, "_err"},  32'(err_timeout), 32'h0);
    endtask

    task automatic wait_log(input string tag, input int n, input int budget);
        int k = 0;
        while (log_byte.size() < n && k < budget) begin
            @(posedge clk); #1;
            k++;
        end
        chk({tag, "_logwait"}, 32'(log_byte.size() >= n), 32'h1);
    endtask

    task automatic wait_vld(input string tag, input int budget);
        int k = 0;
        while (!tx_vld && k < budget) begin
            @(posedge clk); #1;
            k++;
        end
        chk({tag, "_vldwait"}, 32'(tx_vld), 32'h1);
    endtask

    task automatic count_busy(output int n);
        n = 0;
        while (busy && n < 100) begin
            n++;
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int n;
        rst = 1'b1; tx_rdy = 1'b1;
        req = '0; data = '0; last = '0;
        for (int i = 0; i < NREQ; i++) ack_cnt[i] = 0;
        repeat (2) @(posedge clk);
        #1;
        check_reset("por");
        rst = 1'b0;

        // Single two-byte message from requester 0.
        push(0, 8'h41, 1'b0); push(0, 8'h42, 1'b1);
        @(posedge clk); #1;
        chk("t1_grant_busy", 32'(busy), 32'h1);
        chk("t1_grant_gid", 32'(grant_id), 32'h0);
        chk("t1_grant_vld", 32'(tx_vld), 32'h0);
        @(posedge clk); #1;
        chk("t1_cap_vld", 32'(tx_vld), 32'h1);
        chk("t1_cap_data", 32'(tx_data), 32'h41);
        chk("t1_cap_ack", 32'(ack), 32'h1);
        wait_log("t1", 2, 50);
        count_busy(n);
        chk("t1_gap_len", 32'(n), 32'(GAP));
        chk("t1_b0", 32'(log_byte[0]), 32'h41);
        chk("t1_b1", 32'(log_byte[1]), 32'h42);
        chk("t1_spacing", 32'(log_cyc[1] - log_cyc[0]), 32'd2);
        chk("t1_acks", 32'(ack_cnt[0]), 32'd2);
        chk("t1_gid_end", 32'(grant_id), 32'h0);

        // Requesters 1 and 2 start together; no interleaving.
        apply_reset();
        push(1, 8'h11, 1'b0); push(1, 8'h12, 1'b1);
        push(2, 8'h21, 1'b0); push(2, 8'h22, 1'b1);
        wait_log("t2", 4, 100);
        chk("t2_b0", 32'(log_byte[0]), 32'h11);
        chk("t2_b1", 32'(log_byte[1]), 32'h12);
        chk("t2_b2", 32'(log_byte[2]), 32'h21);
        chk("t2_b3", 32'(log_byte[3]), 32'h22);
        chk("t2_gap", 32'(log_cyc[2] - log_cyc[1]), 32'(GAP + 3));

        // Fairness between requesters 0 and 3.
        apply_reset();
        push(0, 8'hA0, 1'b1); push(0, 8'hA0, 1'b1);
        push(3, 8'hB3, 1'b1); push(3, 8'hB3, 1'b1);
        wait_log("t3", 4, 100);
        chk("t3_b0", 32'(log_byte[0]), 32'hA0);
        chk("t3_b1", 32'(log_byte[1]), 32'hB3);
        chk("t3_b2", 32'(log_byte[2]), 32'hA0);
        chk("t3_b3", 32'(log_byte[3]), 32'hB3);

        // Serializer stall holds the byte.
        apply_reset();
        tx_rdy = 1'b0;
        push(0, 8'h55, 1'b1);
        wait_vld("t4", 20);
        for (int k = 0; k < 100; k++) begin
            chk("t4_hold", 32'({tx_vld, tx_data}), 32'h155);
            @(posedge clk); #1;
        end
        chk("t4_acks", 32'(ack_cnt[0]), 32'd1);
        tx_rdy = 1'b1;
        wait_log("t4", 1, 10);
        chk("t4_b0", 32'(log_byte[0]), 32'h55);
        count_busy(n);

        // Reset while requester 0 has a byte in flight.
        apply_reset();
        tx_rdy = 1'b0;
        push(0, 8'h77, 1'b1);
        wait_vld("t5", 20);
        apply_reset();
        check_reset("t5_rst");
        tx_rdy = 1'b1;
        push(0, 8'h01, 1'b1); push(1, 8'h02, 1'b1);
        @(posedge clk); #1;
        chk("t5_first_gid", 32'(grant_id), 32'h0);
        wait_log("t5", 2, 100);
        chk("t5_b0", 32'(log_byte[0]), 32'h01);
        chk("t5_b1", 32'(log_byte[1]), 32'h02);

`ifdef TX_TIMEOUT_EN
        // Requester 2 abandons its message after one byte.
        apply_reset();
        push(2, 8'h33, 1'b0);
        wait_vld("t6", 20);
        @(posedge clk); #1;
        n = 0;
        while (!err_timeout && n < 100) begin
            n++;
            @(posedge clk); #1;
        end
        chk("t6_tmo_cycles", 32'(n), 32'(TMO));
        chk("t6_err", 32'(err_timeout), 32'h1);
        chk("t6_gid", 32'(grant_id), 32'h2);
        count_busy(n);
        chk("t6_gap_len", 32'(n), 32'(GAP));
        chk("t6_err_pulse", 32'(err_timeout), 32'h0);
`else
        // Requester 2 pauses mid-message; the grant must be held.
        apply_reset();
        push(2, 8'h61, 1'b0);
        wait_log("t6", 1, 20);
        repeat (40) @(posedge clk);
        #1;
        chk("t6_hold_busy", 32'(busy), 32'h1);
        chk("t6_hold_gid", 32'(grant_id), 32'h2);
        chk("t6_hold_err", 32'(err_timeout), 32'h0);
        push(2, 8'h62, 1'b1);
        push(0, 8'h0F, 1'b1);
        wait_log("t6", 3, 100);
        chk("t6_b1", 32'(log_byte[1]), 32'h62);
        chk("t6_b2", 32'(log_byte[2]), 32'h0F);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_tx_sched.md
# uart_tx_sched

Message-level round-robin scheduler that shares the single UART transmitter of the serial debug unit among several requesters, such as the command echo, register dump and status reporter. Each requester presents a byte stream ending with a `last` flag. The scheduler grants the transmitter to one requester for an entire message, forwards bytes over a valid/ready handshake, and inserts an idle line gap between messages. It sits between the debug-command logic and the UART TX serializer.

## Interface
Parameters:
- `NREQ`, 4 — number of requesters, 2..8.
- `GAP_TICKS`, 5208 — idle clocks inserted after each message (one bit time at 9600 baud, 50 MHz); 0 disables the gap.
- `TIMEOUT`, 65535 — stall limit in clocks; used only with `TX_TIMEOUT_EN`.

Ports (one clock; reset is synchronous and active-high):
- `clk` in 1 — clock.
- `rst` in 1 — synchronous, active-high reset.
- `req` in NREQ — requester i has a byte pending.
- `data` in 8*NREQ — byte of requester i at bits [8i+7:8i].
- `last` in NREQ — pending byte of requester i ends its message.
- `ack` out NREQ — registered one-cycle pulse: byte of requester i captured.
- `tx_data` out 8 — byte to serializer.
- `tx_vld` out 1 — `tx_data` valid.
- `tx_rdy` in 1 — serializer accepts; a transfer occurs on a clock edge with `tx_vld && tx_rdy`.
- `busy` out 1 — a grant is held or a gap is running.
- `grant_id` out $clog2(NREQ) — current or most recent grantee.
- `err_timeout` out 1 — one-cycle pulse on an aborted message (tied 0 without the macro).

## Operation
- States: IDLE, SEND, GAP.
- **IDLE:**
  - If any `req` is high, pick the first set bit searching from `ptr+1` mod NREQ.
  - Register the pick in `grant_id` and `ptr`, set `busy`, and go to SEND.
  - If no `req` is high, stay in IDLE.
- **SEND, capture:** when `!tx_vld && req[g]`:
  - Load `tx_data <= data[g]`, `tx_vld <= 1`, latch `last[g]` internally.
  - Pulse `ack[g]` in the next cycle.
- **SEND, requester hold rule:** the requester holds `data`/`last`/`req` stable until it sees `ack`. It then presents the next byte or drops `req` within that `ack` cycle.
- **SEND, transfer:**
  - On a transfer edge, `tx_vld <= 0`.
  - If the latched last was set, go to GAP (or to IDLE when `GAP_TICKS==0`); otherwise stay in SEND.
- **SEND, other requesters:** `req` from other requesters is ignored while a grant is held. Message interleaving never occurs.
- **GAP:**
  - The counter runs 0..`GAP_TICKS-1`, then the state goes to IDLE and `busy` drops.
  - `tx_vld` is 0 throughout the gap.
- **Transmitter stall:** `tx_rdy` low holds `tx_vld` and `tx_data` unchanged indefinitely. No further `ack` is issued.
- **Requester drop:** `req[g]` dropping mid-message without a last byte keeps the grant; the scheduler waits (see Configuration).
- **Counter widths:** gap counter width `$clog2(GAP_TICKS+1)`; timeout counter width `$clog2(TIMEOUT+1)`. Neither counter wraps: each saturates at its terminal value and is cleared on state exit.

## Timing
- Reset values: `ack`=0, `tx_data`=0x00, `tx_vld`=0, `busy`=0, `grant_id`=0, `err_timeout`=0, state IDLE, `ptr`=NREQ-1 (so requester 0 has first priority).
- `rst` mid-message takes effect at the next edge. The in-flight byte is dropped (`tx_vld` forced 0) and no `ack` is issued.
- **Latency:**
  - `req` high in IDLE → grant at edge 1.
  - Capture (`tx_vld` 1) at edge 2.
  - `ack` high during cycle 2→3.
- **Throughput:** the earliest next capture is the edge after a transfer, so back-to-back bytes are spaced ≥2 clocks.
- **Gap:** after the last-byte transfer edge, `busy` stays high for exactly `GAP_TICKS` cycles, then 1 cycle in IDLE before a new grant.

## Configuration
- `TX_TIMEOUT_EN` defined:
  - In SEND, count cycles with `!tx_vld && !req[g]`.
  - On reaching `TIMEOUT`, pulse `err_timeout` and go to GAP, releasing the grant.
  - The counter clears whenever a capture occurs.
- `TX_TIMEOUT_EN` undefined:
  - No counter is built and `err_timeout` is constant 0.
  - The grant is held until the last byte transfers.

## Structure
- Shared package `uart_dbg_pkg`:
  - State enum `tx_sched_state_t` (IDLE, SEND, GAP).
  - Constant `BIT_TICKS=5208`, used as the default of `GAP_TICKS`.
- Sub-module `rr_pick`: combinational rotating priority encoder.
  - Inputs: `req[NREQ]`, `ptr`.
  - Outputs: `idx`, `any`.

## Test plan
- **Single message:** req[0] sends 0x41 then 0x42 (last), `tx_rdy`=1 → two transfers 0x41, 0x42, two `ack[0]` pulses, `busy` high through `GAP_TICKS` gap cycles, `grant_id`=0.
- **Simultaneous start:** req[1] and req[2] raised together after reset → requester 1 message completes fully before any byte from requester 2, with a gap between them.
- **Fairness:** req[0] and req[3] continuously issue single-byte messages (0xA0, 0xB3) → transmitted sequence alternates 0xA0, 0xB3, 0xA0, 0xB3.
- **Serializer stall:** `tx_rdy` held 0 for 100 cycles after capture of 0x55 → `tx_vld`=1 and `tx_data`=0x55 stable for all 100 cycles; exactly one `ack`.
- **Reset mid-message:** `rst` asserted for one cycle while `tx_vld`=1 → next cycle all outputs at reset values; next request from requester 0 is granted first.
- **Timeout:** with `TX_TIMEOUT_EN` and `TIMEOUT`=16, req[2] drops after a non-last byte → `err_timeout` pulses 16 cycles later, then GAP, then IDLE.
